// File: rtl/irq_conditioner.sv
// Interrupt pin conditioner: 2-flop sync, optional debounce, per-channel edge-to-pulse.
// Define IRQ_CONDITIONER_DEBOUNCE_EN to compile in the per-channel debounce counters.
module irq_conditioner #(
    parameter int unsigned               NUM_SRC    = 4,
    parameter int unsigned               DEBOUNCE_W = 8,
    parameter logic [NUM_SRC-1:0]        EDGE_RISE  = {NUM_SRC{1'b1}},
    parameter logic [NUM_SRC-1:0]        EDGE_FALL  = {NUM_SRC{1'b0}}
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    output logic [NUM_SRC-1:0] irq_src,
    output logic [NUM_SRC-1:0] src_state_o
);

    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] sync2_q;
    logic [NUM_SRC-1:0] stable_q, stable_d;
    logic [NUM_SRC-1:0] irq_q, irq_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            irq_q    <= '0;
        end else begin
            sync1_q  <= src_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            irq_q    <= irq_d;
        end
    end

`ifdef IRQ_CONDITIONER_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] cnt_q [NUM_SRC];
    logic [DEBOUNCE_W-1:0] cnt_d [NUM_SRC];

    always_ff @(posedge wb_clk_i) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (wb_rst_i) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Commit only once the counter is saturated, so a change needs 2^DEBOUNCE_W mismatching edges.
    always_comb begin
        stable_d = stable_q;
        irq_d    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == {DEBOUNCE_W{1'b1}}) begin
                    stable_d[i] = sync2_q[i];
                    irq_d[i]    = sync2_q[i] ? EDGE_RISE[i] : EDGE_FALL[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        stable_d = stable_q;
        irq_d    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                stable_d[i] = sync2_q[i];
                irq_d[i]    = sync2_q[i] ? EDGE_RISE[i] : EDGE_FALL[i];
            end
        end
    end
`endif

    assign irq_src     = irq_q;
    assign src_state_o = stable_q;

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed self-checking bench for irq_conditioner (DEBOUNCE_W=2, EDGE_FALL=4'b0010).
module tb_irq_conditioner;

    localparam int DW = 2;
`ifdef IRQ_CONDITIONER_DEBOUNCE_EN
    localparam int LAT = 1 + (1 << DW);
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src;
    logic [3:0] irq;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    irq_conditioner #(
        .NUM_SRC    (4),
        .DEBOUNCE_W (DW),
        .EDGE_RISE  (4'b1111),
        .EDGE_FALL  (4'b0010)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .src_i       (src),
        .irq_src     (irq),
        .src_state_o (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample both outputs 1ns later.
    task automatic step(input string tag, input logic [3:0] exp_irq, input logic [3:0] exp_state);
        @(posedge clk);
        #1;
        chk({tag, " irq"}, irq, exp_irq);
        chk({tag, " state"}, state, exp_state);
    endtask

    initial begin
        rst = 1'b1;
        src = 4'b1111;
        repeat (4) step("reset_hi_pins", 4'b0000, 4'b0000);
        src = 4'b0000;
        repeat (3) step("reset_lo_pins", 4'b0000, 4'b0000);
        rst = 1'b0;
        repeat (2) step("idle", 4'b0000, 4'b0000);

        // Single-channel rise: one pulse at edge LAT, none after.
        src = 4'b0001;
        for (int k = 0; k <= LAT + 3; k++)
            step("rise0", (k == LAT) ? 4'b0001 : 4'b0000, (k >= LAT) ? 4'b0001 : 4'b0000);

        // Falling edge on ch0 is masked: level tracks, no pulse.
        src = 4'b0000;
        for (int k = 0; k <= LAT + 2; k++)
            step("fall0_masked", 4'b0000, (k >= LAT) ? 4'b0000 : 4'b0001);

        // Simultaneous rise on ch0 and ch2.
        src = 4'b0101;
        for (int k = 0; k <= LAT + 2; k++)
            step("rise02", (k == LAT) ? 4'b0101 : 4'b0000, (k >= LAT) ? 4'b0101 : 4'b0000);
        src = 4'b0000;
        for (int k = 0; k <= LAT + 2; k++)
            step("fall02_masked", 4'b0000, (k >= LAT) ? 4'b0000 : 4'b0101);

`ifdef IRQ_CONDITIONER_DEBOUNCE_EN
        // Three-cycle glitch is shorter than the debounce window.
        src = 4'b0010;
        repeat (3) step("glitch1_hi", 4'b0000, 4'b0000);
        src = 4'b0000;
        repeat (LAT + 3) step("glitch1_lo", 4'b0000, 4'b0000);
`else
        // Without debounce a one-cycle glitch commits rise, then fall.
        src = 4'b0010;
        step("glitch1_e0", 4'b0000, 4'b0000);
        src = 4'b0000;
        step("glitch1_e1", 4'b0000, 4'b0000);
        step("glitch1_e2", 4'b0010, 4'b0010);
        step("glitch1_e3", 4'b0010, 4'b0000);
        repeat (2) step("glitch1_after", 4'b0000, 4'b0000);
`endif

        // Clean rise then fall on ch1: both edges enabled.
        src = 4'b0010;
        for (int k = 0; k <= LAT + 2; k++)
            step("rise1", (k == LAT) ? 4'b0010 : 4'b0000, (k >= LAT) ? 4'b0010 : 4'b0000);
        src = 4'b0000;
        for (int k = 0; k <= LAT + 2; k++)
            step("fall1", (k == LAT) ? 4'b0010 : 4'b0000, (k >= LAT) ? 4'b0000 : 4'b0010);

        // Reset pulsed on edge 3 while ch3 is pending; pin stays high through release.
        src = 4'b1000;
        for (int k = 0; k <= LAT + 7; k++) begin
            if (k == 3) rst = 1'b1;
            step("rst_mid3",
                 (((k == LAT) && (LAT < 3)) || (k == LAT + 4)) ? 4'b1000 : 4'b0000,
                 (((k >= LAT) && (k < 3)) || (k >= LAT + 4)) ? 4'b1000 : 4'b0000);
            if (k == 3) rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_conditioner.md
IRQ_CONDITIONER -- requirements
Module: irq_conditioner

Interface
REQ-001 Parameter NUM_SRC, default 4: number of interrupt source channels, legal range 1..8.
REQ-002 Parameter DEBOUNCE_W, default 8: debounce counter width per channel, legal range 1..16.
REQ-003 Parameter EDGE_RISE, default 4'b1111: per-channel mask; bit i set means a 0->1 transition on channel i emits an event.
REQ-004 Parameter EDGE_FALL, default 4'b0000: per-channel mask; bit i set means a 1->0 transition on channel i emits an event.
REQ-005 Port wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-007 Port src_i  input  NUM_SRC  raw interrupt pins, asynchronous to wb_clk_i.
REQ-008 Port irq_src  output  NUM_SRC  registered one-cycle event pulses, driven directly into the system block's sticky irq_src inputs.
REQ-009 Port src_state_o  output  NUM_SRC  registered debounced level of each channel.

Function
REQ-010 Each src_i bit SHALL pass through a two-flop synchroniser (sync1, sync2) before any other use.
REQ-011 Each channel SHALL hold a stable bit (drives src_state_o) and a DEBOUNCE_W-bit counter cnt.
REQ-012 When sync2 == stable: cnt SHALL clear to 0 and stable SHALL hold.
REQ-013 When sync2 != stable and cnt < 2^DEBOUNCE_W-1: cnt SHALL increment by 1.
REQ-014 When sync2 != stable and cnt == 2^DEBOUNCE_W-1 (commit): stable SHALL load sync2 and cnt SHALL clear to 0 on the same edge; cnt never wraps.
REQ-015 A change is therefore accepted only after sync2 differs from stable on 2^DEBOUNCE_W consecutive edges; any intervening match restarts the count from 0.
REQ-016 On the commit edge, irq_src[i] SHALL be set to 1 if (new level 1 and EDGE_RISE[i]) or (new level 0 and EDGE_FALL[i]); otherwise it SHALL be 0.
REQ-017 irq_src[i] SHALL be high for exactly one cycle per commit; back-to-back commits on one channel are impossible, since a commit needs at least 2^DEBOUNCE_W cycles.
REQ-018 Latency: with src_i[i] changed before edge 0 and held, src_state_o[i] and irq_src[i] SHALL update on edge 1+2^DEBOUNCE_W.
REQ-019 Channels SHALL be fully independent; simultaneous commits on several channels SHALL pulse all corresponding irq_src bits in the same cycle.
REQ-020 A channel with both EDGE_RISE[i]=0 and EDGE_FALL[i]=0 SHALL still track src_state_o[i] and SHALL never pulse irq_src[i].

Reset
REQ-021 While wb_rst_i is high: sync1, sync2, stable, cnt, irq_src and src_state_o SHALL all be 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count; no event SHALL be emitted on that edge or on the following edge.
REQ-023 A pin held high through reset release SHALL be treated as a 0->1 transition and debounced normally; the resulting rising event is required, not suppressed.

Configuration
REQ-024 Macro IRQ_CONDITIONER_DEBOUNCE_EN defined: the debounce counters of REQ-012..REQ-015 SHALL be compiled in.
REQ-025 Macro IRQ_CONDITIONER_DEBOUNCE_EN undefined: no counters SHALL be generated; commit SHALL occur whenever sync2 != stable, so REQ-018 latency becomes edge 2; DEBOUNCE_W SHALL be ignored.

Verification (DEBOUNCE_W=2, EDGE_RISE=4'b1111, EDGE_FALL=4'b0010, macro defined unless stated)
REQ-026 src_i[0] 0->1 before edge 0, held -> src_state_o[0]=1 and irq_src=4'b0001 for one cycle at edge 5; no further pulses.
REQ-027 src_i[1] high 3 cycles, then low 3 cycles -> src_state_o[1] stays 0 and irq_src[1] never pulses; then src_i[1] 1->0 after a clean rise -> falling pulse on irq_src[1].
REQ-028 src_i[0] and src_i[2] rise on the same edge -> irq_src=4'b0101 for one cycle at edge 5.
REQ-029 src_i[3] rises, wb_rst_i pulsed at edge 3 -> no pulse at edge 5; src_i[3] still high -> rising pulse 2^2+2 edges after reset release.
REQ-030 Macro undefined, src_i[0] 0->1 before edge 0 -> irq_src[0] pulses at edge 2; a 1-cycle glitch produces a pulse.
